imgproc_seq: RTL

- Sequencing controller for the camera image-processing datapath: line buffer, then greyscale, then convolution.
- Tracks pixel position within a frame and latches the filter mode at frame start.
- Suppresses output while the line buffer fills, and produces an output-valid strobe aligned to datapath latency.
- Flags border pixels for zeroing and signals frame completion after the pipeline drains. Sits beside the datapath and drives its select/direction controls and output valid.

---
 rtl/imgproc_seq_if.sv | 39 +++
 rtl/imgproc_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imgproc_seq_if.sv
// imgproc_seq_if
//   Control bundle between the image-processing sequencer and its surroundings.
//   slave  : sequencer side (takes frame/pixel strobes and mode, drives datapath controls)
//   master : source side (drives frame/pixel strobes and mode, observes controls)
//   Signals:
//     iFRAME_START  frame start pulse
//     iDVAL         input pixel valid
//     iMODE[1:0]    requested filter mode
//     oDVAL         datapath output valid
//     oZERO         zero current output pixel (border)
//     oSEL          output mux select (0 greyscale, 1 convolution)
//     oVERTICAL     convolution direction
//     oCOL[10:0]    column of next input pixel
//     oROW[10:0]    row of next input pixel
//     oBUSY         sequencer not idle
//     oFRAME_DONE   last output pixel has left the pipeline
interface imgproc_seq_if;
  logic        iFRAME_START;
  logic        iDVAL;
  logic [1:0]  iMODE;
  logic        oDVAL;
  logic        oZERO;
  logic        oSEL;
  logic        oVERTICAL;
  logic [10:0] oCOL;
  logic [10:0] oROW;
  logic        oBUSY;
  logic        oFRAME_DONE;

  modport slave (
    input  iFRAME_START, iDVAL, iMODE,
    output oDVAL, oZERO, oSEL, oVERTICAL, oCOL, oROW, oBUSY, oFRAME_DONE
  );

  modport master (
    output iFRAME_START, iDVAL, iMODE,
    input  oDVAL, oZERO, oSEL, oVERTICAL, oCOL, oROW, oBUSY, oFRAME_DONE
  );
endinterface

// File: rtl/imgproc_seq.sv
// imgproc_seq
//   Sequencing controller for the camera datapath (line buffer -> greyscale ->
//   convolution). Tracks the pixel position in a frame, latches the filter mode
//   at frame start, holds output valid off while the line buffer fills, delays
//   {valid, border} by the datapath latency and reports frame completion once
//   the pipeline has drained.
//   Ports:
//     iCLK  clock
//     iRST  synchronous active-high reset
//     bus   imgproc_seq_if.slave control bundle (see interface header)
module imgproc_seq #(
  parameter int IMG_W      = 1280,
  parameter int IMG_H      = 960,
  parameter int FILL_LINES = 2,
  parameter int PIPE_LAT   = 3
) (
  input  logic          iCLK,
  input  logic          iRST,
  imgproc_seq_if.slave  bus
);

  localparam int              DCW        = (PIPE_LAT > 7) ? $clog2(PIPE_LAT + 1) : 3;
  localparam logic [10:0]     LAST_COL   = 11'(IMG_W - 1);
  localparam logic [10:0]     LAST_ROW   = 11'(IMG_H - 1);
  localparam logic [10:0]     FILL_ROW   = 11'((FILL_LINES > 0) ? (FILL_LINES - 1) : 0);
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } stateT;

  // With no fill lines the taps are valid from the first pixel.
  localparam stateT START_STATE = (FILL_LINES == 0) ? RUN : FILL;

  stateT                stateR;
  stateT                nextStateS;
  logic [DCW-1:0]       drainCntR;
  logic [DCW-1:0]       nextDrainCntS;
  logic [10:0]          colR;
  logic [10:0]          rowR;
  logic [1:0]           modeR;
  logic                 selR;
  logic                 verticalR;
  logic                 busyR;
  logic                 frameDoneR;
  logic                 frameDoneS;
  logic                 acceptS;
  logic                 qualS;
  logic                 borderS;
  logic                 lastColS;
  logic [PIPE_LAT-1:0]  dvalPipeR;
  logic [PIPE_LAT-1:0]  zeroPipeR;

  // Next-state, pixel qualification and frame-done decode.
  always_comb begin
    nextStateS    = stateR;
    nextDrainCntS = drainCntR;
    acceptS       = 1'b0;
    qualS         = 1'b0;
    lastColS      = (colR == LAST_COL);
    borderS       = (modeR != 2'b00) && ((colR == 11'd0) || lastColS);
    if (bus.iFRAME_START) begin
      // Start or restart: a coincident iDVAL is not counted.
      nextStateS    = START_STATE;
      nextDrainCntS = {DCW{1'b0}};
    end else begin
      case (stateR)
        IDLE: begin
          nextStateS = IDLE;
        end
        FILL: begin
          acceptS = bus.iDVAL;
          if (bus.iDVAL && lastColS && (rowR == FILL_ROW)) begin
            nextStateS = RUN;
          end else begin
            nextStateS = FILL;
          end
        end
        RUN: begin
          acceptS = bus.iDVAL;
          qualS   = bus.iDVAL;
          if (bus.iDVAL && lastColS && (rowR == LAST_ROW)) begin
            nextStateS    = DRAIN;
            nextDrainCntS = {DCW{1'b0}};
          end else begin
            nextStateS = RUN;
          end
        end
        DRAIN: begin
          if (drainCntR == DRAIN_LAST) begin
            nextStateS    = IDLE;
            nextDrainCntS = {DCW{1'b0}};
          end else begin
            nextStateS    = DRAIN;
            nextDrainCntS = drainCntR + DCW'(1);
          end
        end
        default: begin
          nextStateS    = IDLE;
          nextDrainCntS = {DCW{1'b0}};
        end
      endcase
    end
    // The final output pixel shows in the DRAIN cycle whose count is PIPE_LAT-1.
    frameDoneS = (nextStateS == DRAIN) && (nextDrainCntS == DRAIN_LAST);
  end

  // State, drain counter and state-derived status outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateR     <= IDLE;
      drainCntR  <= {DCW{1'b0}};
      busyR      <= 1'b0;
      frameDoneR <= 1'b0;
    end else begin
      stateR     <= nextStateS;
      drainCntR  <= nextDrainCntS;
      busyR      <= (nextStateS != IDLE);
      frameDoneR <= frameDoneS;
    end
  end

  // Pixel position counters; the last pixel of the frame wraps both to zero.
  always_ff @(posedge iCLK) begin
    if (iRST || bus.iFRAME_START) begin
      colR <= 11'd0;
      rowR <= 11'd0;
    end else if (acceptS) begin
      if (lastColS) begin
        colR <= 11'd0;
        rowR <= (rowR == LAST_ROW) ? 11'd0 : (rowR + 11'd1);
      end else begin
        colR <= colR + 11'd1;
      end
    end
  end

  // Mode latch and its decode, held for the whole frame.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      modeR     <= 2'b00;
      selR      <= 1'b0;
      verticalR <= 1'b0;
    end else if (bus.iFRAME_START) begin
      modeR     <= bus.iMODE;
      selR      <= (bus.iMODE != 2'b00);
      verticalR <= (bus.iMODE != 2'b10);
    end
  end

  // Free-running {valid, border} delay line matching the datapath registers.
  always_ff @(posedge iCLK) begin
    if (iRST || bus.iFRAME_START) begin
      dvalPipeR <= {PIPE_LAT{1'b0}};
      zeroPipeR <= {PIPE_LAT{1'b0}};
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        dvalPipeR[i] <= dvalPipeR[i-1];
        zeroPipeR[i] <= zeroPipeR[i-1];
      end
      dvalPipeR[0] <= qualS;
      // Border only travels with a valid pixel, so oZERO is always qualified.
      zeroPipeR[0] <= qualS && borderS;
    end
  end

  assign bus.oDVAL       = dvalPipeR[PIPE_LAT-1];
  assign bus.oZERO       = zeroPipeR[PIPE_LAT-1];
  assign bus.oSEL        = selR;
  assign bus.oVERTICAL   = verticalR;
  assign bus.oCOL        = colR;
  assign bus.oROW        = rowR;
  assign bus.oBUSY       = busyR;
  assign bus.oFRAME_DONE = frameDoneR;

endmodule
